// File: rtl/multi_tick_gen_pkg.sv
// multi_tick_gen_pkg
// Shared constants and width/ratio helpers for the multi-channel tick
// generator. Imported by multi_tick_gen and tick_channel.
package multi_tick_gen_pkg;

  localparam int MS_PER_SEC = 1000;

  // Clock cycles per millisecond; never less than one so the prescaler
  // always has a legal reload value.
  function automatic int calc_prescale(input int clk_hz);
    int q;
    q = clk_hz / MS_PER_SEC;
    return (q < 1) ? 1 : q;
  endfunction

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int calc_ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of a down-counter that must hold values 0..n-1.
  function automatic int calc_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_channel.sv
// tick_channel
// One independent millisecond-based tick channel: holds its period and
// phase counter and emits a registered one-cycle tick at the end of each
// period.
// Optional feature macro: MULTI_TICK_GEN_ONESHOT_EN adds i_oneshot and an
// armed bit so the channel can fire once and then stop.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   i_ms_pulse - one-cycle millisecond strobe from the shared prescaler
//   i_en       - count enable (level)
//   i_we       - load new period and clear phase
//   i_period   - period value for i_we, in ms (0 halts the channel)
//   i_restart  - clear phase, period kept
//   i_oneshot  - (macro only) fire once then wait for re-arm
//   o_tick     - one-cycle pulse at end of period
module tick_channel
  import multi_tick_gen_pkg::*;
#(
  parameter int PERIOD_W       = 16,
  parameter int DEFAULT_PERIOD = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_ms_pulse,
  input  logic                i_en,
  input  logic                i_we,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic                i_restart,
`ifdef MULTI_TICK_GEN_ONESHOT_EN
  input  logic                i_oneshot,
`endif
  output logic                o_tick
);

  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_count;
  logic                r_tick;
  logic                w_clear;
  logic                w_run;
  logic                w_last;

`ifdef MULTI_TICK_GEN_ONESHOT_EN
  logic r_armed;
  logic w_live;
  assign w_live = ~i_oneshot | r_armed;
`endif

  assign w_clear = i_we | i_restart;
  // Comparing against period-1 keeps the counter below the period, so the
  // all-ones period never needs an extra bit.
  assign w_last  = (r_count == (r_period - PERIOD_W'(1)));

`ifdef MULTI_TICK_GEN_ONESHOT_EN
  assign w_run = i_ms_pulse & i_en & (r_period != '0) & w_live;
`else
  assign w_run = i_ms_pulse & i_en & (r_period != '0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_period <= PERIOD_W'(DEFAULT_PERIOD);
      r_count  <= '0;
      r_tick   <= 1'b0;
    end else begin
      // A clear landing on the same ms as the wrap wins: no tick that ms.
      r_tick <= w_run & w_last & ~w_clear;
      if (i_we) begin
        r_period <= i_period;
      end
      if (w_clear) begin
        r_count <= '0;
      end else if (w_run) begin
        r_count <= w_last ? '0 : (r_count + PERIOD_W'(1));
      end
    end
  end

`ifdef MULTI_TICK_GEN_ONESHOT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_armed <= 1'b1;
    end else if (w_clear) begin
      r_armed <= 1'b1;
    end else if (w_run & w_last & i_oneshot) begin
      r_armed <= 1'b0;
    end
  end
`endif

  assign o_tick = r_tick;

endmodule

// File: rtl/multi_tick_gen.sv
// multi_tick_gen
// Shared millisecond prescaler feeding NUM_CH independent, individually
// programmable tick channels.
// Optional feature macro: MULTI_TICK_GEN_ONESHOT_EN adds the per-channel
// oneshot input.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   cfg_we     - period write strobe (one cycle)
//   cfg_ch     - channel addressed by cfg_we; out-of-range values ignored
//   cfg_period - new period in ms, 0 halts the channel
//   ch_en      - per-channel count enable (level)
//   restart    - per-channel phase clear strobe
//   oneshot    - (macro only) per-channel single-fire mode
//   ms_pulse   - one-cycle pulse every millisecond
//   tick       - per-channel one-cycle pulse at end of each period
module multi_tick_gen
  import multi_tick_gen_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int NUM_CH          = 4,
  parameter int PERIOD_W        = 16,
  parameter int DEFAULT_PERIOD  = 1,
  localparam int CH_W           = calc_ch_w(NUM_CH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic [NUM_CH-1:0]   restart,
`ifdef MULTI_TICK_GEN_ONESHOT_EN
  input  logic [NUM_CH-1:0]   oneshot,
`endif
  output logic                ms_pulse,
  output logic [NUM_CH-1:0]   tick
);

  localparam int PRESCALE = calc_prescale(CLOCK_FREQUENCY);
  localparam int PS_W     = calc_cnt_w(PRESCALE);

  logic [PS_W-1:0] r_presc;
  logic            r_ms_pulse;

  // Free-running; nothing but reset touches it, so ms boundaries stay
  // phase-locked to reset release regardless of channel activity.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc    <= PS_W'(PRESCALE - 1);
      r_ms_pulse <= 1'b0;
    end else begin
      r_ms_pulse <= (r_presc == '0);
      if (r_presc == '0) begin
        r_presc <= PS_W'(PRESCALE - 1);
      end else begin
        r_presc <= r_presc - PS_W'(1);
      end
    end
  end

  assign ms_pulse = r_ms_pulse;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic w_we_sel;
    // Exact index match: selects at or beyond NUM_CH hit no channel.
    assign w_we_sel = cfg_we & (cfg_ch == CH_W'(g));

    tick_channel #(
      .PERIOD_W      (PERIOD_W),
      .DEFAULT_PERIOD(DEFAULT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .i_ms_pulse(r_ms_pulse),
      .i_en      (ch_en[g]),
      .i_we      (w_we_sel),
      .i_period  (cfg_period),
      .i_restart (restart[g]),
`ifdef MULTI_TICK_GEN_ONESHOT_EN
      .i_oneshot (oneshot[g]),
`endif
      .o_tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_multi_tick_gen.sv
module tb_multi_tick_gen;

  localparam int CLK_HZ   = 10000;
  localparam int PRESC    = 10;
  localparam int NCH      = 4;
  localparam int PW       = 4;
  localparam int DEF_PER  = 1;

  logic          clk;
  logic          reset;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [PW-1:0] cfg_period;
  logic [NCH-1:0] ch_en;
  logic [NCH-1:0] restart;
`ifdef MULTI_TICK_GEN_ONESHOT_EN
  logic [NCH-1:0] oneshot;
`endif
  logic          ms_pulse;
  logic [NCH-1:0] tick;

  multi_tick_gen #(
    .CLOCK_FREQUENCY(CLK_HZ),
    .NUM_CH         (NCH),
    .PERIOD_W       (PW),
    .DEFAULT_PERIOD (DEF_PER)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_period(cfg_period),
    .ch_en     (ch_en),
    .restart   (restart),
`ifdef MULTI_TICK_GEN_ONESHOT_EN
    .oneshot   (oneshot),
`endif
    .ms_pulse  (ms_pulse),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit             ms;
    logic [NCH-1:0] tk;
    int             cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: time measured in edges since reset release; each
  // channel remembers how many enabled milliseconds have elapsed since its
  // last clear, and ticks whenever that count reaches a multiple of period.
  int m_cyc;
  bit m_prev_ms;
  bit m_last_tick_any;
  int m_period [NCH];
  int m_elapsed[NCH];
  bit m_armed  [NCH];

  task automatic model_step();
    exp_t e;
    bit clr, run, tk, os;
    e.tk = '0;
    if (!reset) begin
      m_cyc = 0;
      m_prev_ms = 0;
      for (int i = 0; i < NCH; i++) begin
        m_period[i] = DEF_PER; m_elapsed[i] = 0; m_armed[i] = 1;
      end
      e.ms = 0;
    end else begin
      m_cyc++;
      e.ms = ((m_cyc % PRESC) == 0);
      for (int i = 0; i < NCH; i++) begin
        os = 0;
`ifdef MULTI_TICK_GEN_ONESHOT_EN
        os = oneshot[i];
`endif
        clr = (cfg_we && (int'(cfg_ch) == i)) || restart[i];
        run = m_prev_ms && ch_en[i] && (m_period[i] != 0) && (!os || m_armed[i]);
        tk  = run && !clr && (((m_elapsed[i] + 1) % (m_period[i] == 0 ? 1 : m_period[i])) == 0);
        if (clr) begin
          m_elapsed[i] = 0;
          m_armed[i] = 1;
          if (cfg_we && (int'(cfg_ch) == i)) m_period[i] = int'(cfg_period);
        end else if (run) begin
          m_elapsed[i]++;
          if (tk && os) m_armed[i] = 0;
        end
        e.tk[i] = tk;
      end
      m_prev_ms = e.ms;
    end
    e.cyc = m_cyc;
    m_last_tick_any = e.ms || (e.tk != '0);
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per clock and compares shortly after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (ms_pulse !== e.ms) begin
        n_fail++;
        $display("FAIL ms_pulse cyc=%0d got=%b want=%b", e.cyc, ms_pulse, e.ms);
      end
      n_cmp++;
      if (tick !== e.tk) begin
        n_fail++;
        $display("FAIL tick cyc=%0d got=%b want=%b", e.cyc, tick, e.tk);
      end
    end
  end

  task automatic step();
    model_step();
    @(negedge clk);
    cfg_we  = 1'b0;
    restart = '0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic write_cfg(input int ch, input int per);
    cfg_we     = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_period = PW'(per);
    step();
  endtask

  task automatic pulse_reset(input int cycles);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ((ms_pulse !== 1'b0) || (tick !== '0)) begin
      n_fail++;
      $display("FAIL reset_immediate got ms=%b tick=%b want ms=0 tick=0", ms_pulse, tick);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < cycles; k++) step();
    reset = 1'b1;
  endtask

  initial begin
    int guard;
    reset      = 1'b0;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_period = '0;
    ch_en      = 4'b1111;
    restart    = '0;
`ifdef MULTI_TICK_GEN_ONESHOT_EN
    oneshot    = '0;
`endif
    @(negedge clk);
    run(3);
    reset = 1'b1;
    run(35);

    write_cfg(2, 3);
    run(70);

    write_cfg(1, 4);
    run(25);
    ch_en[1] = 1'b0;
    run(25);
    ch_en[1] = 1'b1;
    run(60);

    // Restart ch3 on exactly the ms that would end its period.
    write_cfg(3, 2);
    guard = 0;
    while (!(m_prev_ms && (((m_elapsed[3] + 1) % 2) == 0)) && guard < 100) begin
      step();
      guard++;
    end
    n_cmp++;
    if (guard >= 100) begin
      n_fail++;
      $display("FAIL restart_align got guard=%0d want <100", guard);
    end
    restart[3] = 1'b1;
    step();
    run(40);

    write_cfg(0, 15);
    run(170);

    write_cfg(1, 0);
    run(30);

    // Reset while an output is high, mid-period.
    guard = 0;
    while (!m_last_tick_any && guard < 100) begin
      step();
      guard++;
    end
    pulse_reset(3);
    run(35);

`ifdef MULTI_TICK_GEN_ONESHOT_EN
    oneshot[0] = 1'b1;
    write_cfg(0, 2);
    run(60);
    restart[0] = 1'b1;
    step();
    run(60);
    oneshot[0] = 1'b0;
`endif

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        cfg_we     = 1'b1;
        cfg_ch     = 2'($urandom_range(0, 3));
        cfg_period = PW'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 29) == 0) restart = NCH'(1 << $urandom_range(0, NCH - 1));
      if ($urandom_range(0, 39) == 0) ch_en[$urandom_range(0, NCH - 1)] ^= 1'b1;
`ifdef MULTI_TICK_GEN_ONESHOT_EN
      if ($urandom_range(0, 49) == 0) oneshot[$urandom_range(0, NCH - 1)] ^= 1'b1;
`endif
      if (k == 700) begin
        pulse_reset(2);
      end else begin
        step();
      end
    end

    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_tick_gen.md
MULTI_TICK_GEN -- requirements
Module: multi_tick_gen

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 50000000, input clock rate in Hz.
REQ-002 SHALL have parameter NUM_CH, default 4, number of independent tick channels (1..16).
REQ-003 SHALL have parameter PERIOD_W, default 16, width of a channel period in milliseconds.
REQ-004 SHALL have parameter DEFAULT_PERIOD, default 1, period loaded into every channel at reset.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port cfg_we  input  1  period write strobe, one cycle.
REQ-008 SHALL have port cfg_ch  input  CH_W=max(1,$clog2(NUM_CH))  channel selected by cfg_we.
REQ-009 SHALL have port cfg_period  input  PERIOD_W  new period in ms; 0 = channel halted.
REQ-010 SHALL have port ch_en  input  NUM_CH  per-channel count enable, level.
REQ-011 SHALL have port restart  input  NUM_CH  per-channel phase clear, one-cycle strobe.
REQ-012 SHALL have port ms_pulse  output  1  one-cycle pulse every millisecond.
REQ-013 SHALL have port tick  output  NUM_CH  one-cycle pulse per channel at end of each period.

Function
REQ-014 Prescaler SHALL be a down-counter of PRESCALE=CLOCK_FREQUENCY/1000 cycles, reloading PRESCALE-1 at 0; ms_pulse SHALL be registered, high exactly one cycle per PRESCALE cycles.
REQ-015 First ms_pulse SHALL occur PRESCALE cycles after reset deasserts; prescaler SHALL never be affected by cfg_we, restart or ch_en.
REQ-016 Each channel SHALL hold period (PERIOD_W) and count (PERIOD_W) registers; count advances only on ms_pulse while ch_en[i]=1 and period!=0.
REQ-017 On an advancing ms_pulse with count==period-1, count SHALL wrap to 0 and tick[i] SHALL be high the following cycle only; otherwise count increments.
REQ-018 Period=1 SHALL yield tick[i] one cycle after every ms_pulse; period=2^PERIOD_W-1 SHALL wrap without overflow.
REQ-019 ch_en[i]=0 SHALL freeze count (phase preserved) and suppress tick[i].
REQ-020 cfg_we SHALL load period[cfg_ch] and clear count[cfg_ch] in the same cycle; cfg_ch >= NUM_CH SHALL be ignored.
REQ-021 restart[i] SHALL clear count[i] without altering period.
REQ-022 cfg_we or restart on a channel coinciding with its advancing ms_pulse SHALL take priority: count cleared, no tick issued for that ms.
REQ-023 Channels SHALL be fully independent; simultaneous ticks on several channels SHALL all be emitted.

Reset
REQ-024 Reset low SHALL immediately force prescaler to PRESCALE-1, all counts to 0, all periods to DEFAULT_PERIOD, ms_pulse=0, tick=0.
REQ-025 Reset asserted mid-period SHALL discard all phase; counting restarts from zero on release.

Configuration
REQ-026 Macro MULTI_TICK_GEN_ONESHOT_EN SHALL add input oneshot (NUM_CH) and per-channel armed bit, set at reset, by restart[i] or cfg_we to i.
REQ-027 With macro: a channel with oneshot[i]=1 SHALL emit one tick, clear armed, and stop advancing until re-armed; oneshot[i]=0 channels free-run.
REQ-028 Without macro: oneshot port and armed logic SHALL be absent; all channels free-run.

Structure
REQ-029 Package multi_tick_gen_pkg SHALL hold MS_PER_SEC=1000, the PRESCALE computation function and the CH_W width function.
REQ-030 One sub-module tick_channel (period/count/armed registers, tick output) SHALL be instantiated NUM_CH times via generate.

Verification (CLOCK_FREQUENCY=10000, PRESCALE=10, NUM_CH=4)
REQ-031 Release reset at cycle 0 -> ms_pulse at cycles 10, 20, 30; tick[0] (DEFAULT_PERIOD=1) at cycles 11, 21, 31.
REQ-032 Write period 3 to ch2, ch_en=4'b1111 -> tick[2] one cycle after every third ms_pulse; ch0 unaffected.
REQ-033 Drop ch_en[1] for 25 cycles mid-period 4 -> no tick[1]; next tick delayed exactly by ms_pulses missed.
REQ-034 restart[3] asserted in same cycle as ms_pulse ending its period -> no tick[3]; next tick a full period later.
REQ-035 Assert reset low for 3 cycles mid-period -> all outputs 0 immediately; timing identical to REQ-031 after release.
REQ-036 With MULTI_TICK_GEN_ONESHOT_EN, oneshot[0]=1, period 2 -> exactly one tick[0]; restart[0] re-arms for one more.
